rng_harvester: RTL and testbench
================================

# rng_harvester

Consumer-side block for the 16-bit RNG word stream produced by the generator. It accepts one raw word per handshake and runs a repetition-count health test on it. It also applies von Neumann debiasing to the bit pairs and packs the surviving bits into 16-bit output words. Those words are buffered in a small FIFO for downstream readers. It sits between the generator's `Out` bus and any entropy consumer.

## Interface
- `RCT_LIMIT`, 4 — number of consecutive identical accepted words that triggers the alarm (legal range 2..15).
- `FIFO_DEPTH`, 4 — output FIFO entries; must be a power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `rng_in`  in  16  raw RNG word.
- `in_valid`  in  1  `rng_in` is valid.
- `in_ready`  out  1  block can accept a word.
- `clear_alarm`  in  1  one-cycle request to leave the ALARM state.
- `out_data`  out  16  FIFO head word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `alarm`  out  1  sticky health-test failure flag.
- `fifo_level`  out  clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

## Operation
- A word is accepted when `in_valid && in_ready`.
- `in_ready` = (`fifo_level` < FIFO_DEPTH). It depends only on the registered level, not on a same-cycle pop.
- **States**
  - RUN: reset state.
  - ALARM: entered when the repetition-count test fails.
- **Repetition-count test**, on every accepted word in RUN:
  - If `prev_valid` is set and the word equals `prev`, `run_len` ← `run_len`+1; otherwise `run_len` ← 1.
  - `prev` ← word; `prev_valid` ← 1.
  - If the new `run_len` == RCT_LIMIT: go to ALARM, discard the word without debiasing it, and clear the accumulator and its bit count.
- **Debiasing**, on each accepted word in RUN that does not trip the alarm:
  - Examine pairs k = 0..7 in order: hi = w[2k+1], lo = w[2k].
  - If hi ≠ lo, emit hi. If hi == lo, emit nothing.
  - One word yields 0..8 bits.
- **Packing**
  - Emitted bits are appended in order into an accumulator of at least 24 bits, with bit count `acc_cnt`.
  - Emitted bit e_j lands at accumulator position `acc_cnt`+j.
  - If the count after appending is ≥16: push bits [15:0] to the FIFO, shift the remainder down, and set the count to (count−16).
  - At most one push per accepted word.
- **ALARM state**
  - `alarm` = 1.
  - `in_ready` still follows the FIFO level; accepted words are discarded.
  - FIFO contents are retained and stay readable.
- **Leaving ALARM**
  - `clear_alarm` high in ALARM → RUN on the next edge, with `prev_valid`=0, `run_len`=0, and the accumulator cleared.
  - `clear_alarm` is ignored in RUN.
  - If alarm detection and `clear_alarm` occur in the same cycle, detection wins.
- **FIFO**
  - Pop when `out_valid && out_ready`.
  - Push and pop may occur in the same cycle; the level is then unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Values after reset:
  - state RUN, `alarm`=0
  - `in_ready`=1
  - `out_valid`=0, `out_data`=0
  - `fifo_level`=0
  - accumulator=0, `acc_cnt`=0, `run_len`=0, `prev_valid`=0
- Latency: a word accepted at edge N that completes an output word gives `out_valid`=1 with that data in cycle N+1. `out_data` is the registered FIFO head.
- `alarm` rises the cycle after the edge that accepts the RCT_LIMIT-th repeated word.
- `in_ready` falls the cycle after the push that fills the FIFO. It rises the cycle after the first pop from a full FIFO.
- `rst` asserted mid-operation clears all state immediately; FIFO contents are lost.
- All outputs are registered or derived only from registers.

## Test plan
- Reset, then accept 0xAAAA then 0x5555 → one push; `out_data`=0x00FF with `out_valid` high one cycle after the second accept; `acc_cnt`=0.
- Accept 0x6B64 three times (RCT_LIMIT=4) → 6 bits per word; after the third word `out_data`=0xA69A and the accumulator holds 2 leftover bits (1,0).
- Accept 0x1234 four consecutive times → `alarm`=1 after the fourth accept and no FIFO push.
  - Further words are discarded.
  - Pulse `clear_alarm` → state RUN; the next four 0x1234 words trip the alarm again.
- Accept 0x0000 and 0xFFFF alternately for 20 words → no pushes, `alarm` stays 0.
- Hold `out_ready`=0 and stream 0xAAAA/0x5555 pairs → `fifo_level` reaches 4 after 8 words and `in_ready` drops.
  - Raise `out_ready` → four 0x00FF pops; `in_ready` returns the cycle after the first pop.
- Assert `rst` with the FIFO at 2 entries and `acc_cnt`=8 → all outputs take their reset values immediately.

Source files
------------

// File: rtl/rng_harvester_if.sv
// Stream bus between the RNG generator, the harvester and the entropy consumer.
// Both directions are valid/ready: a beat transfers on a rising edge where valid && ready; the sender holds data stable while valid is high and ready is low.
interface rng_harvester_if;
    logic [15:0] rng_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output rng_in, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  rng_in, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/rng_harvester.sv
// Repetition-count health test plus von Neumann debiasing of a 16-bit RNG stream.
// Surviving bits are packed LSB-first into 16-bit words and queued in an output FIFO.
module rng_harvester #(
    parameter int RCT_LIMIT  = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    rng_harvester_if.slave      bus,
    input  logic                clear_alarm,
    output logic                alarm,
    output logic [AW:0]         fifo_level
);
    typedef enum logic {RUN, ALARM} state_t;

    state_t        state, state_nxt;
    logic [15:0]   prev;
    logic          prev_valid;
    logic [3:0]    run_len;
    logic [23:0]   acc;
    logic [4:0]    acc_cnt;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    logic          accept, pop, push, trip;
    logic [3:0]    run_nxt;
    logic [7:0]    deb_bits;
    logic [3:0]    deb_n;
    logic [23:0]   merged;
    logic [4:0]    merged_cnt;

    assign bus.in_ready  = fifo_level < (AW+1)'(FIFO_DEPTH);
    assign bus.out_valid = fifo_level != '0;
    assign bus.out_data  = mem[rd_ptr];
    assign alarm         = state == ALARM;
    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Compact the emitted bits of this word into deb_bits[deb_n-1:0], pair 0 first.
    always_comb begin
        deb_bits = '0;
        deb_n    = '0;
        for (int k = 0; k < 8; k++) begin
            if (bus.rng_in[2*k+1] != bus.rng_in[2*k]) begin
                deb_bits[deb_n[2:0]] = bus.rng_in[2*k+1];
                deb_n = deb_n + 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        trip       = 1'b0;
        push       = 1'b0;
        run_nxt    = 4'd1;
        merged     = acc | ({16'b0, deb_bits} << acc_cnt);
        merged_cnt = acc_cnt + {1'b0, deb_n};
        if (prev_valid && bus.rng_in == prev) begin
            run_nxt = run_len + 4'd1;
        end
        case (state)
            RUN: begin
                if (accept) begin
                    if (run_nxt == 4'(RCT_LIMIT)) begin
                        trip      = 1'b1;
                        state_nxt = ALARM;
                    end else begin
                        push = merged_cnt >= 5'd16;
                    end
                end
            end
            ALARM: begin
                if (clear_alarm) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
            run_len    <= '0;
            acc        <= '0;
            acc_cnt    <= '0;
        end else if (state == ALARM) begin
            if (clear_alarm) begin
                prev_valid <= 1'b0;
                run_len    <= '0;
                acc        <= '0;
                acc_cnt    <= '0;
            end
        end else if (accept) begin
            prev       <= bus.rng_in;
            prev_valid <= 1'b1;
            run_len    <= run_nxt;
            if (trip) begin
                acc     <= '0;
                acc_cnt <= '0;
            end else if (push) begin
                acc     <= merged >> 16;
                acc_cnt <= merged_cnt - 5'd16;
            end else begin
                acc     <= merged;
                acc_cnt <= merged_cnt;
            end
        end
    end

    // A push only happens on an accept, which already guarantees a free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= merged[15:0];
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end
endmodule

// File: tb/tb_rng_harvester.sv
// Bench for rng_harvester: directed vector table, hand sequences for fill/reset,
// and random traffic checked against a bit-queue reference model.
module tb_rng_harvester;
    localparam int RCT_LIMIT  = 4;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_alarm;
    logic       alarm;
    logic [2:0] fifo_level;

    rng_harvester_if bus();

    rng_harvester #(.RCT_LIMIT(RCT_LIMIT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clear_alarm (clear_alarm),
        .alarm       (alarm),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words as bit queues, FIFO as a word queue.
    logic [15:0] exp_q[$];
    bit          m_bits[$];
    bit          m_alarm;
    bit          m_prev_valid;
    int          m_run;
    logic [15:0] m_prev;

    task automatic model_step();
        bit          acc_ok;
        logic [15:0] w;
        acc_ok = bus.in_valid && (exp_q.size() < FIFO_DEPTH);
        if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
        if (m_alarm) begin
            if (clear_alarm) begin
                m_alarm = 0; m_prev_valid = 0; m_run = 0; m_bits.delete();
            end
        end else if (acc_ok) begin
            m_run = (m_prev_valid && bus.rng_in == m_prev) ? m_run + 1 : 1;
            m_prev = bus.rng_in;
            m_prev_valid = 1;
            if (m_run == RCT_LIMIT) begin
                m_alarm = 1;
                m_bits.delete();
            end else begin
                for (int k = 0; k < 8; k++)
                    if (bus.rng_in[2*k+1] != bus.rng_in[2*k]) m_bits.push_back(bus.rng_in[2*k+1]);
                if (m_bits.size() >= 16) begin
                    w = '0;
                    for (int j = 0; j < 16; j++) w[j] = m_bits.pop_front();
                    exp_q.push_back(w);
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete(); m_bits.delete();
            m_alarm = 0; m_prev_valid = 0; m_run = 0; m_prev = '0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("m_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("m_data", 32'(bus.out_data), 32'(exp_q[0]));
            check("m_ready", 32'(bus.in_ready), 32'(exp_q.size() < FIFO_DEPTH));
            check("m_alarm", 32'(alarm), 32'(m_alarm));
            check("m_level", 32'(fifo_level), 32'(exp_q.size()));
        end
    end

    typedef struct packed {
        logic [15:0] word;
        logic        vld;
        logic        ordy;
        logic        clr;
        logic        e_ov;
        logic [15:0] e_od;
        logic        e_al;
        logic [2:0]  e_lvl;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic [15:0] word, logic vld, logic ordy, logic clr,
                                logic e_ov, logic [15:0] e_od, logic e_al, logic [2:0] e_lvl);
        vec_t v;
        v.word = word; v.vld = vld; v.ordy = ordy; v.clr = clr;
        v.e_ov = e_ov; v.e_od = e_od; v.e_al = e_al; v.e_lvl = e_lvl;
        return v;
    endfunction

    task automatic drive(input logic [15:0] word, input logic vld, input logic ordy, input logic clr);
        bus.rng_in = word; bus.in_valid = vld; bus.out_ready = ordy; clear_alarm = clr;
    endtask

    logic [15:0] w;

    initial begin
        drive(16'h0, 1'b0, 1'b0, 1'b0);

        vq.push_back(mk(16'hAAAA, 1, 0, 0, 0, 16'h0000, 0, 0));
        vq.push_back(mk(16'h5555, 1, 0, 0, 1, 16'h00FF, 0, 1));
        vq.push_back(mk(16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0));
        vq.push_back(mk(16'h6B64, 1, 0, 0, 0, 16'h0000, 0, 0));
        vq.push_back(mk(16'h6B64, 1, 0, 0, 0, 16'h0000, 0, 0));
        vq.push_back(mk(16'h6B64, 1, 0, 0, 1, 16'hA69A, 0, 1));
        vq.push_back(mk(16'hAAAA, 1, 1, 0, 0, 16'h0000, 0, 0));
        vq.push_back(mk(16'h5555, 1, 0, 0, 1, 16'h03FD, 0, 1));
        vq.push_back(mk(16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0));
        for (int i = 0; i < 3; i++) vq.push_back(mk(16'h1234, 1, 1, 0, 0, 16'h0000, 0, 0));
        vq.push_back(mk(16'h1234, 1, 1, 0, 0, 16'h0000, 1, 0));
        vq.push_back(mk(16'hAAAA, 1, 1, 0, 0, 16'h0000, 1, 0));
        vq.push_back(mk(16'h5555, 1, 1, 0, 0, 16'h0000, 1, 0));
        vq.push_back(mk(16'h0000, 0, 1, 1, 0, 16'h0000, 0, 0));
        vq.push_back(mk(16'hAAAA, 1, 0, 0, 0, 16'h0000, 0, 0));
        vq.push_back(mk(16'h5555, 1, 0, 0, 1, 16'h00FF, 0, 1));
        vq.push_back(mk(16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0));
        for (int i = 0; i < 3; i++) vq.push_back(mk(16'h1234, 1, 1, 0, 0, 16'h0000, 0, 0));
        vq.push_back(mk(16'h1234, 1, 1, 0, 0, 16'h0000, 1, 0));
        vq.push_back(mk(16'h0000, 0, 1, 1, 0, 16'h0000, 0, 0));

        // Reset values, sampled after a clock edge with reset held.
        @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data",  32'(bus.out_data),  32'd0);
        check("rst_ready", 32'(bus.in_ready),  32'd1);
        check("rst_alarm", 32'(alarm),         32'd0);
        check("rst_level", 32'(fifo_level),    32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].word, vq[i].vld, vq[i].ordy, vq[i].clr);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vq[i].e_ov));
            if (vq[i].e_ov) check($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vq[i].e_od));
            check($sformatf("vec%0d_alarm", i), 32'(alarm), 32'(vq[i].e_al));
            check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vq[i].e_lvl));
        end

        // Equal pairs only: nothing emitted, and alternating words never repeat.
        for (int i = 0; i < 20; i++) begin
            drive((i % 2) ? 16'hFFFF : 16'h0000, 1, 1, 0);
            @(negedge clk);
            check("alt_level", 32'(fifo_level), 32'd0);
            check("alt_alarm", 32'(alarm), 32'd0);
        end

        // Fill the FIFO with the consumer stalled.
        for (int i = 0; i < 8; i++) begin
            drive((i % 2) ? 16'h5555 : 16'hAAAA, 1, 0, 0);
            @(negedge clk);
            check("fill_level", 32'(fifo_level), 32'((i + 1) / 2));
            check("fill_ready", 32'(bus.in_ready), 32'(((i + 1) / 2) < FIFO_DEPTH));
        end
        drive(16'h0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            check("drain_data", 32'(bus.out_data), 32'h00FF);
            @(negedge clk);
            check("drain_level", 32'(fifo_level), 32'(3 - i));
            check("drain_ready", 32'(bus.in_ready), 32'd1);
        end

        // Two entries queued plus 8 bits pending, then reset mid-flight.
        for (int i = 0; i < 5; i++) begin
            drive((i % 2) ? 16'h5555 : 16'hAAAA, 1, 0, 0);
            @(negedge clk);
        end
        check("pre_rst_level", 32'(fifo_level), 32'd2);
        drive(16'h0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data",  32'(bus.out_data),  32'd0);
        check("mid_rst_ready", 32'(bus.in_ready),  32'd1);
        check("mid_rst_alarm", 32'(alarm),         32'd0);
        check("mid_rst_level", 32'(fifo_level),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(16'h5555, 1, 0, 0);
        @(negedge clk);
        drive(16'hAAAA, 1, 0, 0);
        @(negedge clk);
        check("post_rst_level", 32'(fifo_level), 32'd1);
        check("post_rst_data",  32'(bus.out_data), 32'hFF00);
        drive(16'h0, 0, 1, 0);
        @(negedge clk);

        // Random traffic against the model.
        w = 16'h0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0:       w = 16'hAAAA;
                    1:       w = 16'h5555;
                    2:       w = 16'h1234;
                    3:       w = 16'h6B64;
                    default: w = 16'($urandom);
                endcase
            end
            drive(w, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
